// File: rtl/seg_display_scan.sv
// ---------------------------------------------------------------------------
// seg_display_scan
//
// Drives a six-digit, time-multiplexed, common-anode 7-segment display laid
// out as HH.MM.SS from binary hour/minute/second values. One digit is shown
// per scan slot. The field currently being adjusted blinks at a fixed rate.
//
// Ports:
//   clk        input   1  clock
//   rst_n      input   1  asynchronous, active-low reset
//   in_hour    input   8  binary hour (0..23 nominal)
//   in_minute  input   8  binary minute (0..59 nominal)
//   in_second  input   8  binary second (0..59 nominal)
//   blink      input   2  field being set: 0 none, 1 hour, 2 minute, 3 second
//   seg        output  8  segment drive, active-high, {dp,g,f,e,d,c,b,a}
//   an         output  6  digit enable, active-low; an[i] enables digit i
//
// Digit map: 0 hour tens, 1 hour units, 2 minute tens, 3 minute units,
//            4 second tens, 5 second units.
// ---------------------------------------------------------------------------
module seg_display_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_hour,
  input  logic [7:0] in_minute,
  input  logic [7:0] in_second,
  input  logic [1:0] blink,
  output logic [7:0] seg,
  output logic [5:0] an
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic [1:0]    blink_q;
  logic [2:0]    digit_q;
  logic [7:0]    hour_q, minute_q, second_q;
  logic [7:0]    seg_q;
  logic [5:0]    an_q;

  logic          scan_tick;
  logic [2:0]    digit_d;
  logic [7:0]    field_val;
  logic [3:0]    dec_digit;
  logic [1:0]    field_sel;
  logic          blank;
  logic [7:0]    seg_d;
  logic [5:0]    an_d;

  // Segment pattern for a decimal digit, dp clear.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h40;
    endcase
  endfunction

  assign scan_tick = (scan_cnt_q == SCAN_LAST);
  assign digit_d   = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
  // Digits pair up into fields: {0,1} hour, {2,3} minute, {4,5} second.
  assign field_sel = digit_d[2:1];

  // Digit 0 reads the live inputs on the same edge that snapshots them, so
  // every digit of a frame comes from one consistent time value.
  always_comb begin
    field_val = hour_q;
    case (digit_d)
      3'd0:       field_val = in_hour;
      3'd1:       field_val = hour_q;
      3'd2, 3'd3: field_val = minute_q;
      default:    field_val = second_q;
    endcase
  end

  // Even digits show tens, odd digits show units.
  assign dec_digit = digit_d[0] ? 4'(field_val % 8'd10) : 4'(field_val / 8'd10);

  // Blanking is suppressed on the cycle the selection changes, so a newly
  // selected field always starts in its visible half-period.
  assign blank = (blink_q != 2'd0) && (blink == blink_q) && blink_phase_q &&
                 (blink_q == field_sel + 2'd1);

  always_comb begin
    seg_d = 8'h00;
    if (!blank) begin
      if (field_val > 8'd99) seg_d = 8'h40;
      else                   seg_d = {1'b0, seg_code(dec_digit)};
      // Separator dots after the hour and minute units digits.
      if (digit_d == 3'd1 || digit_d == 3'd3) seg_d[7] = 1'b1;
    end
  end

  assign an_d = ~(6'b000001 << digit_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      blink_q       <= 2'd0;
      digit_q       <= 3'd5;
      hour_q        <= 8'd0;
      minute_q      <= 8'd0;
      second_q      <= 8'd0;
      seg_q         <= 8'h00;
      an_q          <= 6'b111111;
    end else begin
      blink_q <= blink;

      if (scan_tick) scan_cnt_q <= '0;
      else           scan_cnt_q <= scan_cnt_q + 1'b1;

      // Restart the blink timer whenever the selected field changes.
      if (blink != blink_q) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q   <= blink_cnt_q + 1'b1;
      end

      if (scan_tick) begin
        digit_q <= digit_d;
        seg_q   <= seg_d;
        an_q    <= an_d;
        if (digit_d == 3'd0) begin
          hour_q   <= in_hour;
          minute_q <= in_minute;
          second_q <= in_second;
        end
      end
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_display_scan
//
// Directed bench for seg_display_scan with SCAN_DIV=4, BLINK_DIV=16.
// Edge numbering restarts at 1 for the first rising clk edge after rst_n
// is released; a digit is loaded on every edge that is a multiple of 4.
// ---------------------------------------------------------------------------
module tb_seg_display_scan;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_hour, in_minute, in_second;
  logic [1:0] blink;
  logic [7:0] seg;
  logic [5:0] an;

  int errorCount = 0;
  int checkCount = 0;

  seg_display_scan #(
    .SCAN_DIV  (4),
    .BLINK_DIV (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_hour   (in_hour),
    .in_minute (in_minute),
    .in_second (in_second),
    .blink     (blink),
    .seg       (seg),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here; value is {an, seg}.
  task automatic checkOutput(input string tag, input logic [13:0] observed,
                             input logic [13:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got an=%b seg=%h, expected an=%b seg=%h",
               tag, observed[13:8], observed[7:0], expected[13:8], expected[7:0]);
    end
  endtask

  task automatic checkSlot(input string tag, input logic [5:0] expAn,
                           input logic [7:0] expSeg);
    checkOutput(tag, {an, seg}, {expAn, expSeg});
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic runEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset a few cycles with the given inputs, release at a falling edge.
  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m,
                               input logic [7:0] s, input logic [1:0] b);
    rst_n     = 1'b0;
    in_hour   = h;
    in_minute = m;
    in_second = s;
    blink     = b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errorCount++;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // ---- Reset, first digit, full frame ----
    applyStimulus(8'd12, 8'd34, 8'd56, 2'd0);
    runEdges(1);  checkSlot("rst_e1",  6'b111111, 8'h00);
    runEdges(2);  checkSlot("rst_e3",  6'b111111, 8'h00);
    runEdges(1);  checkSlot("d0_e4",   6'b111110, 8'h06);
    runEdges(4);  checkSlot("d1_e8",   6'b111101, 8'hDB);
    runEdges(4);  checkSlot("d2_e12",  6'b111011, 8'h4F);
    // Snapshot integrity: second changes while digit 2 is shown.
    in_second = 8'd57;
    runEdges(4);  checkSlot("d3_e16",  6'b110111, 8'hE6);
    runEdges(4);  checkSlot("d4_snap", 6'b101111, 8'h6D);
    runEdges(4);  checkSlot("d5_snap", 6'b011111, 8'h7D);
    runEdges(4);  checkSlot("wrap_d0", 6'b111110, 8'h06);
    runEdges(16); checkSlot("d4_new",  6'b101111, 8'h6D);
    runEdges(4);  checkSlot("d5_new",  6'b011111, 8'h07);

    // ---- Boundary values 00.59.00 ----
    in_hour = 8'd0; in_minute = 8'd59; in_second = 8'd0;
    runEdges(4);  checkSlot("b_d0", 6'b111110, 8'h3F);
    runEdges(4);  checkSlot("b_d1", 6'b111101, 8'hBF);
    runEdges(4);  checkSlot("b_d2", 6'b111011, 8'h6D);
    runEdges(4);  checkSlot("b_d3", 6'b110111, 8'hEF);
    runEdges(4);  checkSlot("b_d4", 6'b101111, 8'h3F);
    runEdges(4);  checkSlot("b_d5", 6'b011111, 8'h3F);
    // Out-of-range hour shows dashes, separator kept on digit 1.
    in_hour = 8'd100;
    runEdges(4);  checkSlot("dash_d0", 6'b111110, 8'h40);
    runEdges(4);  checkSlot("dash_d1", 6'b111101, 8'hC0);
    runEdges(4);  checkSlot("dash_d2", 6'b111011, 8'h6D);

    // ---- Blink hour from reset: blank phase spans edges 18..33 ----
    applyStimulus(8'd12, 8'd34, 8'd56, 2'd1);
    runEdges(4);  checkSlot("bh_d0_lit",  6'b111110, 8'h06);
    runEdges(4);  checkSlot("bh_d1_lit",  6'b111101, 8'hDB);
    runEdges(8);  checkSlot("bh_d3",      6'b110111, 8'hE6);
    runEdges(4);  checkSlot("bh_d4",      6'b101111, 8'h6D);
    runEdges(8);  checkSlot("bh_d0_blank",6'b111110, 8'h00);
    runEdges(4);  checkSlot("bh_d1_blank",6'b111101, 8'h00);
    runEdges(4);  checkSlot("bh_d2_lit",  6'b111011, 8'h4F);

    // ---- Blink select change hour->minute while phase is blank ----
    applyStimulus(8'd12, 8'd34, 8'd56, 2'd1);
    runEdges(18);
    blink = 2'd2;  // change takes effect at edge 19; minute blanks from edge 36
    runEdges(2);  checkSlot("bc_d4",       6'b101111, 8'h6D);
    runEdges(4);  checkSlot("bc_d5",       6'b011111, 8'h7D);
    runEdges(4);  checkSlot("bc_hour_lit0",6'b111110, 8'h06);
    runEdges(4);  checkSlot("bc_hour_lit1",6'b111101, 8'hDB);
    runEdges(4);  checkSlot("bc_min_blank2",6'b111011, 8'h00);
    runEdges(4);  checkSlot("bc_min_blank3",6'b110111, 8'h00);

    // ---- Asynchronous reset during blank phase at digit 3 ----
    rst_n = 1'b0;
    #1;           checkSlot("async_rst", 6'b111111, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    runEdges(3);  checkSlot("rr_e3", 6'b111111, 8'h00);
    runEdges(1);  checkSlot("rr_d0", 6'b111110, 8'h06);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
